// File: rtl/lms_orca_oc_mem_loader_if.sv
// Boot-loader bus bundle: byte stream in, restart pulse, Avalon write port out, boot status out.
// master = loader side (consumes rx stream and start, drives memory port and status).
// slave  = environment side (byte source, memory model, CPU reset controller).
interface lms_orca_oc_mem_loader_if #(
    parameter int ADDR_W = 13
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              start;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic              cpu_reset_req;
    logic              boot_done;
    logic [1:0]        boot_err;

    modport master (
        input  rx_data, rx_valid, start,
        output rx_ready, mem_address, mem_writedata, mem_byteenable,
               mem_chipselect, mem_write, cpu_reset_req, boot_done, boot_err
    );

    modport slave (
        output rx_data, rx_valid, start,
        input  rx_ready, mem_address, mem_writedata, mem_byteenable,
               mem_chipselect, mem_write, cpu_reset_req, boot_done, boot_err
    );
endinterface

// File: rtl/lms_orca_oc_mem_loader.sv
// Loads a framed image (MAGIC, N, N words, CSUM) from a byte stream into program memory, gates CPU reset.
// Latency: memory write strobe 1 cycle after the 4th byte of a word; done/err 1 cycle after last CSUM byte.
// Backpressure: rx_ready low during the write cycle, in DONE/ERR, and in a start cycle.
// Ports: clk, reset_n (async active-low); bus.master carries rx_data/rx_valid/rx_ready, start,
//        mem_address/mem_writedata/mem_byteenable/mem_chipselect/mem_write, cpu_reset_req,
//        boot_done, boot_err (0 none, 1 bad magic, 2 bad length, 3 checksum mismatch).
module lms_orca_oc_mem_loader #(
    parameter int          ADDR_W      = 13,
    parameter int          DEPTH_WORDS = 8192,
    parameter logic [31:0] MAGIC       = 32'h4F524341
) (
    input  logic                     clk,
    input  logic                     reset_n,
    lms_orca_oc_mem_loader_if.master bus
);
    // Wide enough to hold N = DEPTH_WORDS itself.
    localparam int LEN_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [2:0] {
        S_MAGIC, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_word;
    logic [31:0]       r_csum;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic              r_rx_ready;
    logic              r_mem_write;
    logic              r_cpu_reset_req;
    logic              r_boot_done;
    logic [1:0]        r_boot_err;

    logic              w_accept;
    logic              w_last;
    logic [31:0]       w_word;
    logic [LEN_W-1:0]  w_idx_inc;
    logic              w_write_nxt;
    logic              w_done_nxt;
    logic [1:0]        w_err_nxt;
    logic              w_rx_ready_nxt;

    // A start pulse must refuse the byte on offer in the same cycle, so the
    // registered ready is masked by start rather than waiting a cycle.
    assign w_accept  = bus.rx_valid & r_rx_ready & ~bus.start;
    assign w_last    = w_accept & (r_byte_cnt == 2'd3);
    // Little-endian assembly: the newest byte enters at the top, so after four
    // bytes the first one received sits in bits [7:0].
    assign w_word    = {bus.rx_data, r_word[31:8]};
    assign w_idx_inc = r_idx + LEN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = 1'b0;
        w_done_nxt  = r_boot_done;
        w_err_nxt   = r_boot_err;
        if (bus.start) begin
            w_state_nxt = S_MAGIC;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 2'd0;
        end else begin
            case (r_state)
                S_MAGIC: if (w_last) begin
                    if (w_word == MAGIC) begin
                        w_state_nxt = S_LEN;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 2'd1;
                    end
                end
                S_LEN: if (w_last) begin
                    if ((w_word == 32'd0) || (w_word > 32'(DEPTH_WORDS))) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 2'd2;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: if (w_last) begin
                    w_state_nxt = S_WRITE;
                    w_write_nxt = 1'b1;
                end
                S_WRITE: w_state_nxt = (w_idx_inc < r_len) ? S_DATA : S_CSUM;
                S_CSUM: if (w_last) begin
                    if (w_word == r_csum) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 2'd3;
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                S_ERR:   w_state_nxt = S_ERR;
                default: w_state_nxt = S_MAGIC;
            endcase
        end
        w_rx_ready_nxt = (w_state_nxt == S_MAGIC) || (w_state_nxt == S_LEN) ||
                         (w_state_nxt == S_DATA)  || (w_state_nxt == S_CSUM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_MAGIC;
            r_byte_cnt      <= 2'd0;
            r_word          <= 32'd0;
            r_csum          <= 32'd0;
            r_wdata         <= 32'd0;
            r_addr          <= '0;
            r_len           <= '0;
            r_idx           <= '0;
            r_rx_ready      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_cpu_reset_req <= 1'b1;
            r_boot_done     <= 1'b0;
            r_boot_err      <= 2'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_rx_ready      <= w_rx_ready_nxt;
            r_mem_write     <= w_write_nxt;
            r_boot_done     <= w_done_nxt;
            r_boot_err      <= w_err_nxt;
            r_cpu_reset_req <= (w_state_nxt != S_DONE);

            if (w_write_nxt) begin
                r_wdata <= w_word;
                r_addr  <= r_idx[ADDR_W-1:0];
            end else begin
                r_wdata <= 32'd0;
                r_addr  <= '0;
            end

            if (w_accept) begin
                r_word     <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if (bus.start) begin
                r_byte_cnt <= 2'd0;
                r_idx      <= '0;
                r_csum     <= 32'd0;
            end else begin
                if ((r_state == S_LEN) && w_last) begin
                    r_len <= w_word[LEN_W-1:0];
                end
                // The write strobe is on the bus this cycle; fold it into the sum.
                if (r_state == S_WRITE) begin
                    r_csum <= r_csum + r_wdata;
                    r_idx  <= w_idx_inc;
                end
            end
        end
    end

    assign bus.rx_ready       = r_rx_ready & ~bus.start;
    assign bus.mem_address    = r_addr;
    assign bus.mem_writedata  = r_wdata;
    assign bus.mem_byteenable = {4{r_mem_write}};
    assign bus.mem_chipselect = r_mem_write;
    assign bus.mem_write      = r_mem_write;
    assign bus.cpu_reset_req  = r_cpu_reset_req;
    assign bus.boot_done      = r_boot_done;
    assign bus.boot_err       = r_boot_err;
endmodule
